// File: rtl/book_pkg.sv
// Shared types and default widths for the order-reference / price-level path.
package book_pkg;

  localparam int IDX_W_DEF   = 10;
  localparam int SHARE_W_DEF = 32;

  typedef enum logic [1:0] {OP_NONE, OP_ADD, OP_DEL, OP_EXEC} op_e;

  typedef enum logic {ST_CLEAR, ST_RUN} state_e;

  // Reference layouts at the default widths; modules rebuild them from their own parameters.
  typedef struct packed {
    logic                     valid;
    logic [63-IDX_W_DEF:0]    tag;
    logic [15:0]              locate;
    logic [31:0]              price;
    logic                     buy_sell;
    logic [SHARE_W_DEF-1:0]   shares;
  } order_entry_t;

  typedef struct packed {
    logic [15:0]              locate;
    logic [31:0]              price;
    logic                     buy_sell;
    logic signed [SHARE_W_DEF:0] delta;
  } lvl_delta_t;

endpackage

// File: rtl/order_ram.sv
// Simple dual-port sync RAM, 1-cycle read. A write landing on the address being read
// in the same cycle is forwarded so the reader sees the new data.
module order_ram #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];
  logic [DW-1:0] r_q;
  logic          r_fwd_hit;
  logic [DW-1:0] r_fwd_data;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_q        <= r_mem[i_raddr];
    r_fwd_hit  <= i_we && (i_waddr == i_raddr);
    r_fwd_data <= i_wdata;
  end

  assign o_rdata = r_fwd_hit ? r_fwd_data : r_q;

endmodule

// File: rtl/order_ref_table.sv
// Direct-mapped live-order table keyed by ITCH refNum; emits one signed price-level
// delta per applied add/delete/execute. Three-stage pipeline, one message per cycle.
module order_ref_table
  import book_pkg::*;
#(
  parameter int IDX_W   = IDX_W_DEF,
  parameter int SHARE_W = SHARE_W_DEF
) (
  input  logic                 clkIn,
  input  logic                 rstBIn,
  input  logic                 addValidIn,
  input  logic                 delValidIn,
  input  logic                 execValidIn,
  input  logic [63:0]          refNumIn,
  input  logic [15:0]          locateIn,
  input  logic [31:0]          priceIn,
  input  logic [63:0]          sharesIn,
  input  logic                 buySellIn,
  output logic                 readyOut,
  output logic                 lvlValidOut,
  output logic [15:0]          lvlLocateOut,
  output logic [31:0]          lvlPriceOut,
  output logic                 lvlBuySellOut,
  output logic signed [SHARE_W:0] lvlDeltaOut,
  output logic                 collisionOut,
  output logic                 missOut,
  output logic                 dropOut
);

  localparam int TAG_W = 64 - IDX_W;

  typedef struct packed {
    logic               valid;
    logic [TAG_W-1:0]   tag;
    logic [15:0]        locate;
    logic [31:0]        price;
    logic               buy_sell;
    logic [SHARE_W-1:0] shares;
  } entry_t;

  typedef struct packed {
    op_e                op;
    logic               drop;
    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic [15:0]        locate;
    logic [31:0]        price;
    logic               buy_sell;
    logic [SHARE_W-1:0] shares;
  } msg_t;

  localparam int ENTRY_W = $bits(entry_t);

  state_e           r_state;
  logic [IDX_W-1:0] r_cnt;
  msg_t             r_s0, r_s1;
  msg_t             w_msg;
  logic [1:0]       w_nstb;
  logic             w_any;
  logic             w_unused_shares;

  assign readyOut        = (r_state == ST_RUN);
  assign w_unused_shares = ^sharesIn[63:SHARE_W];

  // Clear sweep: one entry per cycle, then RUN until the next reset.
  always_ff @(posedge clkIn or negedge rstBIn) begin
    if (!rstBIn) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == {IDX_W{1'b1}}) r_state <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign w_nstb = {1'b0, addValidIn} + {1'b0, delValidIn} + {1'b0, execValidIn};
  assign w_any  = addValidIn | delValidIn | execValidIn;

  always_comb begin
    w_msg          = '0;
    w_msg.op       = OP_NONE;
    w_msg.drop     = w_any && ((w_nstb > 2'd1) || !readyOut);
    w_msg.idx      = refNumIn[IDX_W-1:0];
    w_msg.tag      = refNumIn[63:IDX_W];
    w_msg.locate   = locateIn;
    w_msg.price    = priceIn;
    w_msg.buy_sell = buySellIn;
    w_msg.shares   = sharesIn[SHARE_W-1:0];
    if (!w_msg.drop) begin
      if (addValidIn)       w_msg.op = OP_ADD;
      else if (delValidIn)  w_msg.op = OP_DEL;
      else if (execValidIn) w_msg.op = OP_EXEC;
    end
  end

  always_ff @(posedge clkIn or negedge rstBIn) begin
    if (!rstBIn) begin
      r_s0 <= '0;
      r_s1 <= '0;
    end else begin
      r_s0 <= w_msg;
      r_s1 <= r_s0;
    end
  end

  logic [ENTRY_W-1:0] w_rd_bits;
  entry_t             w_rd;
  entry_t             w_wentry;
  logic               w_we;
  logic               w_hit;
  logic               w_lvl_v, w_coll, w_miss;
  logic [15:0]        w_loc;
  logic [31:0]        w_px;
  logic               w_bs;
  logic signed [SHARE_W:0] w_delta;
  logic               w_ram_we;
  logic [IDX_W-1:0]   w_ram_waddr;
  logic [ENTRY_W-1:0] w_ram_wdata;

  assign w_rd  = entry_t'(w_rd_bits);
  assign w_hit = w_rd.valid && (w_rd.tag == r_s1.tag);

  always_comb begin
    w_we     = 1'b0;
    w_wentry = w_rd;
    w_lvl_v  = 1'b0;
    w_coll   = 1'b0;
    w_miss   = 1'b0;
    w_loc    = w_rd.locate;
    w_px     = w_rd.price;
    w_bs     = w_rd.buy_sell;
    w_delta  = '0;
    case (r_s1.op)
      OP_ADD: begin
        w_we     = 1'b1;
        w_wentry = '{valid: 1'b1, tag: r_s1.tag, locate: r_s1.locate, price: r_s1.price,
                     buy_sell: r_s1.buy_sell, shares: r_s1.shares};
        w_lvl_v  = 1'b1;
        w_coll   = w_rd.valid && (w_rd.tag != r_s1.tag);
        w_loc    = r_s1.locate;
        w_px     = r_s1.price;
        w_bs     = r_s1.buy_sell;
        w_delta  = $signed({1'b0, r_s1.shares});
      end
      OP_DEL: begin
        if (w_hit) begin
          w_we           = 1'b1;
          w_wentry.valid = 1'b0;
          w_lvl_v        = 1'b1;
          w_delta        = -$signed({1'b0, w_rd.shares});
        end else begin
          w_miss = 1'b1;
        end
      end
      OP_EXEC: begin
        if (w_hit) begin
          w_we    = 1'b1;
          w_lvl_v = 1'b1;
          // Over-execution clamps to the resting size and frees the entry.
          if (r_s1.shares < w_rd.shares) begin
            w_wentry.shares = w_rd.shares - r_s1.shares;
            w_delta         = -$signed({1'b0, r_s1.shares});
          end else begin
            w_wentry.valid = 1'b0;
            w_delta        = -$signed({1'b0, w_rd.shares});
          end
        end else begin
          w_miss = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign w_ram_we    = (r_state == ST_CLEAR) ? 1'b1  : w_we;
  assign w_ram_waddr = (r_state == ST_CLEAR) ? r_cnt : r_s1.idx;
  assign w_ram_wdata = (r_state == ST_CLEAR) ? '0    : ENTRY_W'(w_wentry);

  order_ram #(.AW(IDX_W), .DW(ENTRY_W)) u_ram (
    .clk     (clkIn),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_raddr (r_s0.idx),
    .o_rdata (w_rd_bits)
  );

  always_ff @(posedge clkIn or negedge rstBIn) begin
    if (!rstBIn) begin
      lvlValidOut   <= 1'b0;
      collisionOut  <= 1'b0;
      missOut       <= 1'b0;
      dropOut       <= 1'b0;
      lvlLocateOut  <= '0;
      lvlPriceOut   <= '0;
      lvlBuySellOut <= 1'b0;
      lvlDeltaOut   <= '0;
    end else begin
      lvlValidOut  <= w_lvl_v;
      collisionOut <= w_coll;
      missOut      <= w_miss;
      dropOut      <= r_s1.drop;
      if (w_lvl_v) begin
        lvlLocateOut  <= w_loc;
        lvlPriceOut   <= w_px;
        lvlBuySellOut <= w_bs;
        lvlDeltaOut   <= w_delta;
      end
    end
  end

endmodule

// File: tb/tb_order_ref_table.sv
// Directed bench for order_ref_table: expected responses queued at issue time, popped
// and compared by an independent monitor whenever the DUT reports an outcome.
module tb_order_ref_table;

  localparam int IDX_W   = 10;
  localparam int SHARE_W = 32;
  localparam int DW      = SHARE_W + 1;
  localparam int EW      = 32 + 4 + 16 + 32 + 1 + DW;

  logic        clkIn = 1'b0;
  logic        rstBIn;
  logic        addValidIn, delValidIn, execValidIn;
  logic [63:0] refNumIn;
  logic [15:0] locateIn;
  logic [31:0] priceIn;
  logic [63:0] sharesIn;
  logic        buySellIn;
  logic        readyOut, lvlValidOut, lvlBuySellOut, collisionOut, missOut, dropOut;
  logic [15:0] lvlLocateOut;
  logic [31:0] lvlPriceOut;
  logic signed [DW-1:0] lvlDeltaOut;

  order_ref_table #(.IDX_W(IDX_W), .SHARE_W(SHARE_W)) dut (
    .clkIn(clkIn), .rstBIn(rstBIn),
    .addValidIn(addValidIn), .delValidIn(delValidIn), .execValidIn(execValidIn),
    .refNumIn(refNumIn), .locateIn(locateIn), .priceIn(priceIn),
    .sharesIn(sharesIn), .buySellIn(buySellIn), .readyOut(readyOut),
    .lvlValidOut(lvlValidOut), .lvlLocateOut(lvlLocateOut), .lvlPriceOut(lvlPriceOut),
    .lvlBuySellOut(lvlBuySellOut), .lvlDeltaOut(lvlDeltaOut),
    .collisionOut(collisionOut), .missOut(missOut), .dropOut(dropOut)
  );

  // clock / reset
  always #2 clkIn = ~clkIn;

  int unsigned cyc = 0;
  always @(posedge clkIn) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  logic [EW-1:0] exp_q[$];

  task automatic chk(input string nm, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
  endtask

  // driver tasks
  task automatic drive(input logic a, input logic d, input logic x, input logic [63:0] rf,
                       input logic [63:0] sh, input logic [15:0] loc, input logic [31:0] px,
                       input logic bs);
    @(posedge clkIn); #1;
    addValidIn = a; delValidIn = d; execValidIn = x;
    refNumIn = rf; sharesIn = sh; locateIn = loc; priceIn = px; buySellIn = bs;
  endtask

  task automatic idle();
    @(posedge clkIn); #1;
    addValidIn = 1'b0; delValidIn = 1'b0; execValidIn = 1'b0;
  endtask

  task automatic expect_out(input logic v, input logic c, input logic m, input logic dr,
                            input logic [15:0] loc, input logic [31:0] px, input logic bs,
                            input int delta);
    logic signed [DW-1:0] dd;
    logic [31:0] due;
    dd  = DW'(delta);
    due = 32'(cyc + 3);
    exp_q.push_back({due, v, c, m, dr, loc, px, bs, dd});
  endtask

  task automatic exp_lvl(input logic c, input logic [15:0] loc, input logic [31:0] px,
                         input logic bs, input int delta);
    expect_out(1'b1, c, 1'b0, 1'b0, loc, px, bs, delta);
  endtask

  task automatic exp_miss();
    expect_out(1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 32'd0, 1'b0, 0);
  endtask

  task automatic exp_drop();
    expect_out(1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 32'd0, 1'b0, 0);
  endtask

  // scoreboard monitor
  always @(negedge clkIn) begin
    if (rstBIn && (lvlValidOut || missOut || dropOut || collisionOut)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_out: got v=%0b c=%0b m=%0b d=%0b expected none (cycle %0d)",
                 lvlValidOut, collisionOut, missOut, dropOut, cyc);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        chk("latency", cyc, e[EW-1 -: 32]);
        chk("flags", {lvlValidOut, collisionOut, missOut, dropOut}, e[EW-33 -: 4]);
        if (e[EW-33]) begin
          chk("locate", lvlLocateOut, e[EW-37 -: 16]);
          chk("price", lvlPriceOut, e[EW-53 -: 32]);
          chk("side", lvlBuySellOut, e[DW]);
          chk("delta", lvlDeltaOut, $signed(e[DW-1:0]));
        end
      end
    end
  end

  initial begin
    int t;
    int unsigned c0;
    rstBIn = 1'b0;
    addValidIn = 0; delValidIn = 0; execValidIn = 0;
    refNumIn = '0; sharesIn = '0; locateIn = '0; priceIn = '0; buySellIn = 0;
    repeat (3) @(posedge clkIn);
    @(negedge clkIn);
    chk("rst_ready", readyOut, 0);
    chk("rst_lvl_valid", lvlValidOut, 0);
    chk("rst_drop", dropOut, 0);
    chk("rst_miss", missOut, 0);
    chk("rst_collision", collisionOut, 0);
    chk("rst_delta", lvlDeltaOut, 0);

    @(posedge clkIn); #1;
    rstBIn = 1'b1;
    c0 = cyc;

    // Strobe during the clear sweep is dropped.
    drive(1, 0, 0, 64'h5, 64'd300, 16'd7, 32'd1000, 1); exp_drop();
    idle();

    t = 0;
    while (readyOut !== 1'b1 && t < 3000) begin
      @(posedge clkIn); #1;
      t++;
    end
    chk("ready_rise_cycles", cyc - c0, 1 << IDX_W);

    // add, then two back-to-back execs on the same order, then exec on the freed slot
    drive(1, 0, 0, 64'h5, 64'd300, 16'd7, 32'd1000, 1); exp_lvl(0, 16'd7, 32'd1000, 1, 300);
    drive(0, 0, 1, 64'h5, 64'd100, 16'd0, 32'd0, 0);    exp_lvl(0, 16'd7, 32'd1000, 1, -100);
    drive(0, 0, 1, 64'h5, 64'd500, 16'd0, 32'd0, 0);    exp_lvl(0, 16'd7, 32'd1000, 1, -200);
    drive(0, 0, 1, 64'h5, 64'd1, 16'd0, 32'd0, 0);      exp_miss();
    idle();

    drive(0, 1, 0, 64'h9, 64'd0, 16'd0, 32'd0, 0);      exp_miss();
    idle();

    // collision on index 5
    drive(1, 0, 0, 64'h5, 64'd50, 16'd7, 32'd1000, 0);   exp_lvl(0, 16'd7, 32'd1000, 0, 50);
    drive(1, 0, 0, 64'h405, 64'd70, 16'd8, 32'd2000, 1); exp_lvl(1, 16'd8, 32'd2000, 1, 70);
    drive(0, 1, 0, 64'h5, 64'd0, 16'd0, 32'd0, 0);       exp_miss();
    drive(0, 1, 0, 64'h405, 64'd0, 16'd0, 32'd0, 0);     exp_lvl(0, 16'd8, 32'd2000, 1, -70);
    idle();

    // two strobes at once: dropped, table untouched
    drive(1, 1, 0, 64'h40, 64'd10, 16'd2, 32'd20, 1);    exp_drop();
    idle();
    drive(0, 1, 0, 64'h40, 64'd0, 16'd0, 32'd0, 0);      exp_miss();
    idle();

    // exact-size exec frees the entry
    drive(1, 0, 0, 64'h20, 64'd40, 16'd3, 32'd555, 0);   exp_lvl(0, 16'd3, 32'd555, 0, 40);
    idle(); idle();
    drive(0, 0, 1, 64'h20, 64'd40, 16'd0, 32'd0, 0);     exp_lvl(0, 16'd3, 32'd555, 0, -40);
    idle(); idle();
    drive(0, 1, 0, 64'h20, 64'd0, 16'd0, 32'd0, 0);      exp_miss();
    idle();

    // upper share bits are ignored
    drive(1, 0, 0, 64'h30, 64'hFFFF_0000_0000_0010, 16'd1, 32'd9, 1); exp_lvl(0, 16'd1, 32'd9, 1, 16);
    idle();
    drive(0, 1, 0, 64'h30, 64'd0, 16'd0, 32'd0, 0);      exp_lvl(0, 16'd1, 32'd9, 1, -16);
    idle();

    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(posedge clkIn);
      t++;
    end
    repeat (10) @(posedge clkIn);
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
